// File: rtl/datapath_memory.sv
// MEM stage of the RV32I pipeline: data-memory handshake with timeout, store lane
// replication, load extension, front-end stall and the MEM/WB pipeline register.
module datapath_memory #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MisalignW,
    output logic        BusErrW
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          is_load, mem_op, sz_byte, sz_half, sz_word, misalign, access;
    logic          req, stall, bus_err, rd_take;
    logic [3:0]    be;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_ext;

    // Access decode; unlisted funct3 codes fall through to word size
    assign is_load  = (ResultSrcM == 2'b01) & ~MemWriteM;
    assign mem_op   = MemWriteM | (ResultSrcM == 2'b01);
    assign sz_byte  = (funct3M == 3'b000) | (is_load & (funct3M == 3'b100));
    assign sz_half  = (funct3M == 3'b001) | (is_load & (funct3M == 3'b101));
    assign sz_word  = ~sz_byte & ~sz_half;
    assign misalign = mem_op & ((sz_half & ALUResultM[0]) |
                                (sz_word & (ALUResultM[1:0] != 2'b00)));
    assign access   = mem_op & ~misalign;

    // Lane placement for stores and lane selection for loads
    always_comb begin
        be        = 4'b1111;
        mem_wdata = WriteDataM;
        if (sz_byte) begin
            be        = 4'b0001 << ALUResultM[1:0];
            mem_wdata = {4{WriteDataM[7:0]}};
        end else if (sz_half) begin
            be        = 4'b0011 << ALUResultM[1:0];
            mem_wdata = {2{WriteDataM[15:0]}};
        end
        case (ALUResultM[1:0])
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (sz_byte)
            load_ext = funct3M[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (sz_half)
            load_ext = funct3M[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        else
            load_ext = mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req      = 1'b0;
        stall    = 1'b0;
        bus_err  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (!mem_ready) begin
                        stall    = 1'b1;
                        state_nx = WAIT;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            WAIT: begin
                // Timeout retires without a request so the bus sees the abort
                if (cnt == CW'(TIMEOUT)) begin
                    bus_err  = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    req = 1'b1;
                    if (mem_ready) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        stall  = 1'b1;
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Reset gates the bus strobes so an outstanding request drops immediately
    assign mem_req  = reset & req;
    assign StallM   = reset & stall;
    assign mem_we   = mem_req & MemWriteM;
    assign mem_be   = mem_req ? be : 4'b0000;
    assign mem_addr = {ALUResultM[31:2], 2'b00};
    assign rd_take  = mem_req & mem_ready & ~mem_we;

    // MEM/WB register: bubble while stalled, data fields held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else if (stall) begin
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            MisalignW  <= 1'b0;
            BusErrW    <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM & ~misalign & ~bus_err;
            ResultSrcW <= ResultSrcM;
            MisalignW  <= misalign;
            BusErrW    <= bus_err;
            if (rd_take)
                ReadDataW <= load_ext;
        end
    end
endmodule
